// File: rtl/md5_mc_core.sv
// md5_mc_core -- iterative MD5 compression engine with NUM_CH chaining contexts.
//
// One pre-padded 512-bit block is accepted per handshake. The block runs through
// 64 MD5 steps, RPC steps per clock. The result is then folded into the chaining
// context of the block's channel. Channels may interleave multi-block messages
// block by block. A block flagged last512 also emits a tagged 128-bit digest as a
// one-cycle o_fDone pulse. o_data and o_ch hold until the next digest.
//
// Parameters:
//   NUM_CH  number of chaining contexts (power of 2, >= 1)
//   RPC     MD5 steps per clock: 1, 2 or 4
//
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset
//   i_start  block valid, accepted when i_start & o_ready
//   o_ready  engine idle, can accept a block
//   i_ch     context index of the offered block
//   i_first  first block of a message: chain from IV
//   last512  last block of a message: produce digest
//   i_data   block, word M[j] at i_data[511-32j -: 32]
//   o_data   digest, valid while o_fDone, held afterwards
//   o_ch     channel of o_data
//   o_fDone  one-cycle digest-valid pulse
//   o_fBusy  block in flight
//
// Configuration macro MD5_BSWAP_EN:
//   defined   - input words are byte-swapped (i_data in message byte order) and
//               o_data is the canonical digest byte string.
//   undefined - input words are used as-is and o_data = {A,B,C,D} raw words.

module md5_mc_core #(
  parameter int NUM_CH = 4,
  parameter int RPC    = 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  output logic            o_ready,
  input  logic [CH_W-1:0] i_ch,
  input  logic            i_first,
  input  logic            last512,
  input  logic [511:0]    i_data,
  output logic [127:0]    o_data,
  output logic [CH_W-1:0] o_ch,
  output logic            o_fDone,
  output logic            o_fBusy
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
    $error("md5_mc_core: RPC must be 1, 2 or 4");
  end
  if (NUM_CH < 1 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_num_ch
    $error("md5_mc_core: NUM_CH must be a power of 2");
  end

  localparam int          CYC      = 64 / RPC;
  localparam logic [5:0]  LAST_CYC = 6'(CYC - 1);
  localparam logic [127:0] IV      = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // MD5 step helpers (RFC 1321)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] md5_k(input logic [5:0] i);
    logic [31:0] k;
    case (i)
      6'd0:  k = 32'hd76aa478;  6'd1:  k = 32'he8c7b756;  6'd2:  k = 32'h242070db;  6'd3:  k = 32'hc1bdceee;
      6'd4:  k = 32'hf57c0faf;  6'd5:  k = 32'h4787c62a;  6'd6:  k = 32'ha8304613;  6'd7:  k = 32'hfd469501;
      6'd8:  k = 32'h698098d8;  6'd9:  k = 32'h8b44f7af;  6'd10: k = 32'hffff5bb1;  6'd11: k = 32'h895cd7be;
      6'd12: k = 32'h6b901122;  6'd13: k = 32'hfd987193;  6'd14: k = 32'ha679438e;  6'd15: k = 32'h49b40821;
      6'd16: k = 32'hf61e2562;  6'd17: k = 32'hc040b340;  6'd18: k = 32'h265e5a51;  6'd19: k = 32'he9b6c7aa;
      6'd20: k = 32'hd62f105d;  6'd21: k = 32'h02441453;  6'd22: k = 32'hd8a1e681;  6'd23: k = 32'he7d3fbc8;
      6'd24: k = 32'h21e1cde6;  6'd25: k = 32'hc33707d6;  6'd26: k = 32'hf4d50d87;  6'd27: k = 32'h455a14ed;
      6'd28: k = 32'ha9e3e905;  6'd29: k = 32'hfcefa3f8;  6'd30: k = 32'h676f02d9;  6'd31: k = 32'h8d2a4c8a;
      6'd32: k = 32'hfffa3942;  6'd33: k = 32'h8771f681;  6'd34: k = 32'h6d9d6122;  6'd35: k = 32'hfde5380c;
      6'd36: k = 32'ha4beea44;  6'd37: k = 32'h4bdecfa9;  6'd38: k = 32'hf6bb4b60;  6'd39: k = 32'hbebfbc70;
      6'd40: k = 32'h289b7ec6;  6'd41: k = 32'heaa127fa;  6'd42: k = 32'hd4ef3085;  6'd43: k = 32'h04881d05;
      6'd44: k = 32'hd9d4d039;  6'd45: k = 32'he6db99e5;  6'd46: k = 32'h1fa27cf8;  6'd47: k = 32'hc4ac5665;
      6'd48: k = 32'hf4292244;  6'd49: k = 32'h432aff97;  6'd50: k = 32'hab9423a7;  6'd51: k = 32'hfc93a039;
      6'd52: k = 32'h655b59c3;  6'd53: k = 32'h8f0ccc92;  6'd54: k = 32'hffeff47d;  6'd55: k = 32'h85845dd1;
      6'd56: k = 32'h6fa87e4f;  6'd57: k = 32'hfe2ce6e0;  6'd58: k = 32'ha3014314;  6'd59: k = 32'h4e0811a1;
      6'd60: k = 32'hf7537e82;  6'd61: k = 32'hbd3af235;  6'd62: k = 32'h2ad7d2bb;  6'd63: k = 32'heb86d391;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  // Shift amount depends only on the round (i[5:4]) and the step position mod 4.
  function automatic logic [4:0] md5_s(input logic [5:0] i);
    logic [4:0] s;
    case ({i[5:4], i[1:0]})
      4'b0000: s = 5'd7;   4'b0001: s = 5'd12;  4'b0010: s = 5'd17;  4'b0011: s = 5'd22;
      4'b0100: s = 5'd5;   4'b0101: s = 5'd9;   4'b0110: s = 5'd14;  4'b0111: s = 5'd20;
      4'b1000: s = 5'd4;   4'b1001: s = 5'd11;  4'b1010: s = 5'd16;  4'b1011: s = 5'd23;
      4'b1100: s = 5'd6;   4'b1101: s = 5'd10;  4'b1110: s = 5'd15;  4'b1111: s = 5'd21;
      default: s = 5'd0;
    endcase
    return s;
  endfunction

  // Message word index; 4-bit arithmetic gives the mod-16 wrap for free.
  function automatic logic [3:0] md5_g(input logic [5:0] i);
    logic [3:0] g;
    case (i[5:4])
      2'd0:    g = i[3:0];
      2'd1:    g = i[3:0] * 4'd5 + 4'd1;
      2'd2:    g = i[3:0] * 4'd3 + 4'd5;
      2'd3:    g = i[3:0] * 4'd7;
      default: g = 4'd0;
    endcase
    return g;
  endfunction

  function automatic logic [31:0] md5_f(input logic [5:0] i, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    logic [31:0] f;
    case (i[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (b & d) | (c & ~d);
      2'd2:    f = b ^ c ^ d;
      2'd3:    f = c ^ (b | ~d);
      default: f = 32'h0;
    endcase
    return f;
  endfunction

  // s is never zero, so the right shift by 32-s stays within the word.
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

  function automatic logic [31:0] word_in(input logic [31:0] w);
`ifdef MD5_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [127:0] digest_out(input logic [127:0] h);
`ifdef MD5_BSWAP_EN
    return {word_in(h[127:96]), word_in(h[95:64]), word_in(h[63:32]), word_in(h[31:0])};
`else
    return h;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath storage
  // ---------------------------------------------------------------------------
  state_t           state_r;
  state_t           state_nx_s;
  logic [127:0]     ctx_r [NUM_CH];
  logic [31:0]      m_r [16];
  logic [31:0]      a_r, b_r, c_r, d_r;
  logic [127:0]     h0_r;
  logic [CH_W-1:0]  ch_r;
  logic             last_r;
  logic [5:0]       rnd_r;

  logic             accept_s;
  logic [127:0]     chain_in_s;
  logic [127:0]     sum_s;
  logic [31:0]      na_s, nb_s, nc_s, nd_s;
  logic [31:0]      va_s, vb_s, vc_s, vd_s, tmp_s, rot_s;
  logic [5:0]       idx_s;

  assign accept_s = i_start & (state_r == ST_IDLE);

  // Select the chaining input for an offered block: IV on first, else its context.
  always_comb begin
    chain_in_s = IV;
    if (i_first) begin
      chain_in_s = IV;
    end else begin
      chain_in_s = ctx_r[i_ch];
    end
  end

  // Feed-forward addition of the block result onto its chaining input.
  always_comb begin
    sum_s = {a_r + h0_r[127:96], b_r + h0_r[95:64], c_r + h0_r[63:32], d_r + h0_r[31:0]};
  end

  // RPC chained MD5 steps starting at step rnd_r*RPC.
  always_comb begin
    va_s  = a_r;
    vb_s  = b_r;
    vc_s  = c_r;
    vd_s  = d_r;
    idx_s = 6'd0;
    tmp_s = 32'h0;
    rot_s = 32'h0;
    for (int k = 0; k < RPC; k++) begin
      idx_s = 6'(int'(rnd_r) * RPC + k);
      tmp_s = va_s + md5_f(idx_s, vb_s, vc_s, vd_s) + md5_k(idx_s) + m_r[md5_g(idx_s)];
      rot_s = vb_s + rotl(tmp_s, md5_s(idx_s));
      va_s  = vd_s;
      vd_s  = vc_s;
      vc_s  = vb_s;
      vb_s  = rot_s;
    end
    na_s = va_s;
    nb_s = vb_s;
    nc_s = vc_s;
    nd_s = vd_s;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rnd_r == LAST_CYC) begin
          state_nx_s = ST_FIN;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FIN:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the state register.
  always_comb begin
    o_ready = 1'b0;
    o_fBusy = 1'b1;
    case (state_r)
      ST_IDLE: begin
        o_ready = 1'b1;
        o_fBusy = 1'b0;
      end
      ST_RUN, ST_FIN: begin
        o_ready = 1'b0;
        o_fBusy = 1'b1;
      end
      default: begin
        o_ready = 1'b0;
        o_fBusy = 1'b1;
      end
    endcase
  end

  // Block latch, working registers, context update and digest output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ctx_r[c] <= IV;
      end
      for (int j = 0; j < 16; j++) begin
        m_r[j] <= 32'h0;
      end
      a_r     <= 32'h0;
      b_r     <= 32'h0;
      c_r     <= 32'h0;
      d_r     <= 32'h0;
      h0_r    <= 128'h0;
      ch_r    <= '0;
      last_r  <= 1'b0;
      rnd_r   <= 6'd0;
      o_data  <= 128'h0;
      o_ch    <= '0;
      o_fDone <= 1'b0;
    end else begin
      o_fDone <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            for (int j = 0; j < 16; j++) begin
              m_r[j] <= word_in(i_data[511-32*j -: 32]);
            end
            ch_r   <= i_ch;
            last_r <= last512;
            rnd_r  <= 6'd0;
            h0_r   <= chain_in_s;
            a_r    <= chain_in_s[127:96];
            b_r    <= chain_in_s[95:64];
            c_r    <= chain_in_s[63:32];
            d_r    <= chain_in_s[31:0];
          end
        end
        ST_RUN: begin
          a_r   <= na_s;
          b_r   <= nb_s;
          c_r   <= nc_s;
          d_r   <= nd_s;
          rnd_r <= rnd_r + 6'd1;
        end
        ST_FIN: begin
          ctx_r[ch_r] <= sum_s;
          if (last_r) begin
            o_data  <= digest_out(sum_s);
            o_ch    <= ch_r;
            o_fDone <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_mc_core.sv
// tb_md5_mc_core -- directed self-checking bench for md5_mc_core (RPC=1, NUM_CH=4).
// Known MD5 vectors are driven in message byte order and converted to the
// DUT's word convention according to MD5_BSWAP_EN.

module tb_md5_mc_core;

  localparam int CH_W    = 2;
  localparam int TB_RPC  = 1;
  localparam int EXP_LAT = 64 / TB_RPC + 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            ready;
  logic [CH_W-1:0] ch;
  logic            first;
  logic            last;
  logic [511:0]    data;
  logic [127:0]    dout;
  logic [CH_W-1:0] dch;
  logic            done;
  logic            busy;

  int tests = 0;
  int fails = 0;

  md5_mc_core #(.NUM_CH(4), .RPC(TB_RPC)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .o_ready (ready),
    .i_ch    (ch),
    .i_first (first),
    .last512 (last),
    .i_data  (data),
    .o_data  (dout),
    .o_ch    (dch),
    .o_fDone (done),
    .o_fBusy (busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] D_A     = 128'h0cc175b9c0f1b6a831c399e269772661;
  localparam logic [127:0] D_AB    = 128'h187ef4436122d1cc2f40dc2b92f0eba0;
  localparam logic [127:0] D_A64   = 128'h014842d480b571495a4a0363793f7367;

  function automatic logic [31:0] sw(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Block in message byte order with word 0 and word 14 set, everything else zero.
  function automatic logic [511:0] mk(input logic [31:0] w0, input logic [31:0] w14);
    logic [511:0] b;
    b = '0;
    b[511:480] = w0;
    b[63:32]   = w14;
    return b;
  endfunction

  function automatic logic [511:0] tb_blk(input logic [511:0] b);
    logic [511:0] r;
    r = b;
`ifndef MD5_BSWAP_EN
    for (int j = 0; j < 16; j++) r[511-32*j -: 32] = sw(b[511-32*j -: 32]);
`endif
    return r;
  endfunction

  function automatic logic [127:0] tb_dig(input logic [127:0] d);
    logic [127:0] r;
    r = d;
`ifndef MD5_BSWAP_EN
    for (int j = 0; j < 4; j++) r[127-32*j -: 32] = sw(d[127-32*j -: 32]);
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: timeout waiting for DUT", tag);
  endtask

  // Offer a block and wait for the accepting edge; leaves time at #1 after it.
  task automatic offer(input logic [CH_W-1:0] c, input logic f, input logic l,
                       input logic [511:0] blk, input logic hold);
    bit acc = 1'b0;
    ch = c; first = f; last = l; data = tb_blk(blk); start = 1'b1;
    for (int t = 0; t < 300 && !acc; t++) begin
      acc = ready;
      @(posedge clk); #1;
    end
    if (!acc) timeout("offer");
    if (!hold) start = 1'b0;
  endtask

  // Latency counts the accept edge as 1 up to the edge that raises o_fDone.
  task automatic wait_done(output int lat);
    bit seen = 1'b0;
    int n = 1;
    while (!seen && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) timeout("wait_done");
    lat = n;
  endtask

  task automatic wait_idle(output int dones);
    bit idle = 1'b0;
    dones = 0;
    for (int t = 0; t < 300 && !idle; t++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (ready) idle = 1'b1;
    end
    if (!idle) timeout("wait_idle");
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int t = 0; t < cycles; t++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    logic [127:0] held;

    reset = 1'b1; start = 1'b0; ch = '0; first = 1'b0; last = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_busy",  128'(busy),  128'(0));
    chk("rst_done",  128'(done),  128'(0));
    chk("rst_data",  dout,        128'h0);
    chk("rst_ch",    128'(dch),   128'(0));

    // "abc" on ch0, single block
    offer(2'd0, 1'b1, 1'b1, mk(32'h61626380, 32'h18000000), 1'b0);
    chk("abc_busy",  128'(busy),  128'(1));
    chk("abc_nrdy",  128'(ready), 128'(0));
    wait_done(lat);
    chk("abc_lat",   128'(lat),   128'(EXP_LAT));
    chk("abc_data",  dout,        tb_dig(D_ABC));
    chk("abc_ch",    128'(dch),   128'(0));
    chk("abc_rdy_in_done", 128'(ready), 128'(1));
    held = dout;
    @(posedge clk); #1;
    chk("abc_pulse", 128'(done),  128'(0));
    chk("abc_held",  dout,        held);

    // Empty message on ch1
    offer(2'd1, 1'b1, 1'b1, mk(32'h80000000, 32'h00000000), 1'b0);
    wait_done(lat);
    chk("empty_lat",  128'(lat),  128'(EXP_LAT));
    chk("empty_data", dout,       tb_dig(D_EMPTY));
    chk("empty_ch",   128'(dch),  128'(1));

    // "a" on ch2 and "ab" on ch3 back to back with start held high
    offer(2'd2, 1'b1, 1'b1, mk(32'h61800000, 32'h08000000), 1'b1);
    ch = 2'd3; data = tb_blk(mk(32'h61628000, 32'h10000000));
    wait_done(lat);
    chk("a_data", dout,          tb_dig(D_A));
    chk("a_ch",   128'(dch),     128'(2));
    chk("a_rdy",  128'(ready),   128'(1));
    @(posedge clk); #1;
    start = 1'b0;
    chk("ab_accepted_busy", 128'(busy), 128'(1));
    wait_done(lat);
    chk("ab_lat",  128'(lat),    128'(EXP_LAT));
    chk("ab_data", dout,         tb_dig(D_AB));
    chk("ab_ch",   128'(dch),    128'(3));

    // Two-block 64 x 'a' on ch0 with "abc" on ch1 between the blocks
    offer(2'd0, 1'b1, 1'b0, {16{32'h61616161}}, 1'b0);
    wait_idle(cnt);
    chk("a64_b1_nodone", 128'(cnt), 128'(0));
    offer(2'd1, 1'b1, 1'b1, mk(32'h61626380, 32'h18000000), 1'b0);
    wait_done(lat);
    chk("mid_abc_data", dout,      tb_dig(D_ABC));
    chk("mid_abc_ch",   128'(dch), 128'(1));
    offer(2'd0, 1'b0, 1'b1, mk(32'h80000000, 32'h00020000), 1'b0);
    wait_done(lat);
    chk("a64_data", dout,      tb_dig(D_A64));
    chk("a64_ch",   128'(dch), 128'(0));

    // Dirty ch0 with a non-last block, then reset in the middle of a block
    offer(2'd0, 1'b1, 1'b0, {16{32'h61616161}}, 1'b0);
    wait_idle(cnt);
    offer(2'd0, 1'b0, 1'b1, mk(32'h80000000, 32'h00000000), 1'b0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_ready", 128'(ready), 128'(1));
    chk("rst_mid_busy",  128'(busy),  128'(0));
    count_done(80, cnt);
    chk("rst_mid_nodone", 128'(cnt), 128'(0));
    offer(2'd0, 1'b0, 1'b1, mk(32'h61626380, 32'h18000000), 1'b0);
    wait_done(lat);
    chk("rst_iv_data", dout,      tb_dig(D_ABC));
    chk("rst_iv_ch",   128'(dch), 128'(0));

    // start held while busy with changing data: only the first block is hashed
    offer(2'd1, 1'b1, 1'b1, mk(32'h80000000, 32'h00000000), 1'b1);
    for (int t = 0; t < EXP_LAT - 6; t++) begin
      data = {16{$urandom}};
      ch = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done(lat);
    chk("hold_data", dout,      tb_dig(D_EMPTY));
    chk("hold_ch",   128'(dch), 128'(1));
    count_done(80, cnt);
    chk("hold_single_done", 128'(cnt), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
